// File: rtl/fetch_redirect_unit.sv
// IF-stage PC register and I-cache fetch sequencer, with a metadata pipe that carries
// branch-prediction state from IF to MEM so the predictor can update and redirect.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0060,
  parameter int unsigned META_STAGES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcmux_in,
  input  logic [31:0] pred_pc_in,
  input  logic [1:0]  pred_outcome_in,
  input  logic        btb_hit_in,
  input  logic        mem_misprediction,
  input  logic        pipe_stall,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  output logic        imem_read,
  output logic [31:0] imem_address,
  output logic [31:0] if_pc_out,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        mem_valid,
  output logic [31:0] mem_pc_out,
  output logic [31:0] mem_predicted_pcmux_out,
  output logic [1:0]  mem_predicted_branch_outcome,
  output logic        mem_BTB_hit,
  output logic        flush
);

  localparam int unsigned LAST = META_STAGES - 1;

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        pending_reg;
  logic [31:0] pending_target_reg;
  logic [31:0] skid_instr_reg;
  logic [31:0] skid_pc_reg;
  logic [31:0] skid_ppc_reg;
  logic [1:0]  skid_po_reg;
  logic        skid_hit_reg;
  logic [31:0] id_instr_reg;

  logic [31:0] target;
  logic        accept;
  logic        entry_valid;
  logic [31:0] entry_instr;
  logic [31:0] entry_pc;
  logic [31:0] entry_ppc;
  logic [1:0]  entry_po;
  logic        entry_hit;

  assign target = pcmux_in & ~32'h3;
  assign accept = (state_reg == FETCH) && imem_resp && !pending_reg;

  // What ID receives when the pipe moves: the skid entry, a fresh response, or a bubble.
  always_comb begin
    entry_valid = 1'b0;
    entry_instr = '0;
    entry_pc    = '0;
    entry_ppc   = '0;
    entry_po    = '0;
    entry_hit   = 1'b0;
    if (state_reg == HOLD) begin
      entry_valid = 1'b1;
      entry_instr = skid_instr_reg;
      entry_pc    = skid_pc_reg;
      entry_ppc   = skid_ppc_reg;
      entry_po    = skid_po_reg;
      entry_hit   = skid_hit_reg;
    end else if (accept) begin
      entry_valid = 1'b1;
      entry_instr = imem_rdata;
      entry_pc    = pc_reg;
      entry_ppc   = pred_pc_in;
      entry_po    = pred_outcome_in;
      entry_hit   = btb_hit_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= FETCH;
      pc_reg             <= RESET_PC;
      pending_reg        <= 1'b0;
      pending_target_reg <= '0;
      skid_instr_reg     <= '0;
      skid_pc_reg        <= '0;
      skid_ppc_reg       <= '0;
      skid_po_reg        <= '0;
      skid_hit_reg       <= 1'b0;
    end else if (flush) begin
      // A response arriving with the flush is wrong-path; only a missing one needs the latch.
      if (state_reg == HOLD) begin
        state_reg <= FETCH;
        pc_reg    <= target;
      end else if (imem_resp) begin
        pc_reg      <= target;
        pending_reg <= 1'b0;
      end else begin
        pending_reg        <= 1'b1;
        pending_target_reg <= target;
      end
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_resp) begin
            if (pending_reg) begin
              pc_reg      <= pending_target_reg;
              pending_reg <= 1'b0;
            end else if (pipe_stall) begin
              state_reg      <= HOLD;
              skid_instr_reg <= imem_rdata;
              skid_pc_reg    <= pc_reg;
              skid_ppc_reg   <= pred_pc_in;
              skid_po_reg    <= pred_outcome_in;
              skid_hit_reg   <= btb_hit_in;
            end else begin
              pc_reg <= target;
            end
          end
        end
        HOLD: begin
          if (!pipe_stall) begin
            state_reg <= FETCH;
            pc_reg    <= target;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_instr_reg <= '0;
    end else if (flush) begin
      id_instr_reg <= '0;
    end else if (!pipe_stall) begin
      id_instr_reg <= entry_instr;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < META_STAGES; gi++) begin : g_stage
      logic        v_reg;
      logic [31:0] pc_reg;
      logic [31:0] ppc_reg;
      logic [1:0]  po_reg;
      logic        hit_reg;
      logic        v_next;
      logic [31:0] pc_next;
      logic [31:0] ppc_next;
      logic [1:0]  po_next;
      logic        hit_next;

      if (gi == 0) begin : g_head
        assign v_next   = entry_valid;
        assign pc_next  = entry_pc;
        assign ppc_next = entry_ppc;
        assign po_next  = entry_po;
        assign hit_next = entry_hit;
      end else begin : g_tail
        assign v_next   = g_stage[gi-1].v_reg;
        assign pc_next  = g_stage[gi-1].pc_reg;
        assign ppc_next = g_stage[gi-1].ppc_reg;
        assign po_next  = g_stage[gi-1].po_reg;
        assign hit_next = g_stage[gi-1].hit_reg;
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
          v_reg   <= 1'b0;
          pc_reg  <= '0;
          ppc_reg <= '0;
          po_reg  <= '0;
          hit_reg <= 1'b0;
        end else if (!pipe_stall) begin
          v_reg   <= v_next;
          pc_reg  <= pc_next;
          ppc_reg <= ppc_next;
          po_reg  <= po_next;
          hit_reg <= hit_next;
        end
      end
    end
  endgenerate

  assign flush        = mem_misprediction & g_stage[LAST].v_reg;
  assign imem_read    = (state_reg == FETCH);
  assign imem_address = pc_reg;
  assign if_pc_out    = pc_reg;

  assign id_valid = g_stage[0].v_reg;
  assign id_instr = id_instr_reg;
  assign id_pc    = g_stage[0].pc_reg;

  assign mem_valid                    = g_stage[LAST].v_reg;
  assign mem_pc_out                   = g_stage[LAST].pc_reg;
  assign mem_predicted_pcmux_out      = g_stage[LAST].ppc_reg;
  assign mem_predicted_branch_outcome = g_stage[LAST].po_reg;
  assign mem_BTB_hit                  = g_stage[LAST].hit_reg;

endmodule
